vend_sequencer: RTL and testbench
=================================

# vend_sequencer

Credit-and-dispense controller for the cola vending machine. It takes single-cycle coin and cancel events from the key-conditioning logic and keeps a running credit in half-yuan units. It drives a timed cola-dispense pulse and a train of timed change pulses, one 0.5-yuan coin per pulse. It sits between the key front end and the actuator/LED outputs and is the only block allowed to assert `po_cola` or `po_money`.

## Interface
- `PRICE`, default 5: cola price in 0.5-yuan units. Legal range 1..12.
- `PULSE_CYC`, default 5_000_000: actuator pulse length in sclk cycles (100 ms at 50 MHz). Minimum 1.
- `GAP_CYC`, default 5_000_000: idle gap after every pulse, in sclk cycles. Minimum 1.
- `sclk`, in, 1: system clock. The block has one clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `coin_half`, in, 1: one-cycle pulse, 0.5 yuan inserted.
- `coin_one`, in, 1: one-cycle pulse, 1.0 yuan inserted.
- `cancel`, in, 1: one-cycle pulse, refund request.
- `po_cola`, out, 1: dispense actuator. Held high for `PULSE_CYC` cycles.
- `po_money`, out, 1: change actuator. Each high pulse of `PULSE_CYC` cycles returns 0.5 yuan.
- `coin_reject`, out, 1: one-cycle pulse when a coin arrives while the block is busy.
- `credit`, out, 4: current credit in 0.5-yuan units.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: collecting coins.
  - VEND: `po_cola` high.
  - CHANGE: `po_money` high.
  - GAP: all actuators low.
- IDLE, per cycle:
  - Computed addition: `add = coin_half*1 + coin_one*2`. Both coins in the same cycle gives `add = 3`; both are accepted.
  - Computed sum: `sum = credit + add`.
  - If `sum >= PRICE`: go to VEND, `credit <= sum - PRICE`. `cancel` in the same cycle is ignored.
  - Else if `cancel` and `sum > 0`: go to CHANGE, `credit <= sum - 1`.
  - Else `credit <= sum`. Cancel with zero credit is a no-op.
- VEND: after `PULSE_CYC` cycles, go to GAP.
- CHANGE: after `PULSE_CYC` cycles, go to GAP.
- GAP: after `GAP_CYC` cycles:
  - if `credit > 0`, go to CHANGE and `credit <= credit - 1`;
  - else go to IDLE.
- Non-IDLE states:
  - Each coin pulse produces a `coin_reject` pulse in the following cycle. Two simultaneous coins produce one reject pulse.
  - Credit is unchanged by these coins.
  - `cancel` is ignored.
- Width: credit never exceeds `PRICE + 2`, which is at most 14, so 4 bits are sufficient and no saturation logic is needed.
- Reset values: `state=IDLE`, `credit=0`, `po_cola=0`, `po_money=0`, `coin_reject=0`, `busy=0`, pulse timer cleared.
- Reset mid-operation: all actuators drop immediately (asynchronously), and all credit in flight is lost.

## Timing
- All outputs are registered.
- Coin sampled at edge t: `credit` shows the new value from t+1.
- Coin that reaches `PRICE` at edge t: `po_cola` rises at t+1 and falls at t+1+`PULSE_CYC`. Exactly `PULSE_CYC` high cycles.
- Every pulse is followed by exactly `GAP_CYC` low cycles before the next pulse or the return to IDLE.
- `busy` rises in the same cycle as the first actuator edge. It falls in the cycle IDLE is re-entered.
- In IDLE, a coin is accepted on every cycle; back-to-back pulses are legal.
- Every `po_money` rise is accompanied by `credit` decrementing by 1 in the same cycle.

## Structure
- Shared package `vend_pkg` holds:
  - the state encoding: IDLE=0, VEND=1, CHANGE=2, GAP=3, 2 bits;
  - the credit width constant `CREDIT_W=4`;
  - the coin value constants `HALF=1`, `ONE=2`.
- Sub-module `pulse_timer`:
  - a loadable down-counter, 26 bits wide;
  - inputs: `load`, `len`;
  - output: `done`, a one-cycle pulse when the count reaches zero.
  - It is shared by the VEND, CHANGE and GAP timing.
- The top level contains the FSM, the credit register and the output registers.

## Test plan
All scenarios use `PRICE=5`, `PULSE_CYC=4`, `GAP_CYC=2`.
1. Five `coin_half` pulses, spaced 3 cycles apart -> `credit` steps 1,2,3,4, then `po_cola` high for 4 cycles starting the cycle after the 5th pulse. No `po_money`. `credit=0`. `busy` clears 6 cycles after `po_cola` rises.
2. Three `coin_one` pulses -> `po_cola` 4 cycles, 2-cycle gap, then one `po_money` pulse of 4 cycles, 2-cycle gap, IDLE. `credit` ends at 0.
3. `coin_half` and `coin_one` in the same cycle, twice -> credit goes 3, then 6. Vend, then one change pulse, same as scenario 2.
4. Two `coin_one` pulses, then `cancel` -> four `po_money` pulses, each 4 high / 2 low. `credit` goes 4→3→2→1→0. No `po_cola`.
5. `coin_one` asserted during VEND -> `coin_reject` high for 1 cycle in the next cycle. `credit` and the pulse timing are unchanged.
6. `rst_n` pulled low 2 cycles into VEND -> `po_cola=0` and `credit=0` without waiting for a clock edge. After release, the block sits in IDLE with `busy=0`.

Source files
------------

// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the cola vending credit-and-dispense controller:
// FSM state encoding, credit register width, coin values and timer width.
// -----------------------------------------------------------------------------
package vend_pkg;

  // Credit is kept in 0.5-yuan units; PRICE + 2 <= 14 always fits.
  localparam int CREDIT_W = 4;

  // Pulse/gap timer width; 2^26 cycles is ~1.3 s at 50 MHz.
  localparam int TIMER_W = 26;

  // Coin values in 0.5-yuan units.
  localparam logic [CREDIT_W-1:0] HALF = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] ONE  = CREDIT_W'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // collecting coins
    VEND   = 2'd1,  // po_cola high
    CHANGE = 2'd2,  // po_money high, one 0.5-yuan coin returned
    GAP    = 2'd3   // all actuators low between pulses
  } state_t;

endpackage

// File: rtl/pulse_timer.sv
// -----------------------------------------------------------------------------
// pulse_timer
// Loadable down-counter shared by the VEND, CHANGE and GAP phases.
// A load of length L makes 'done' pulse for one cycle L cycles later, so a
// state entered on the load edge lasts exactly L cycles if the FSM leaves it
// on the edge where 'done' is seen. A load takes priority over a pending done.
//
// Ports:
//   sclk  - system clock
//   rst_n - asynchronous active-low reset
//   load  - restart the count with 'len' (len >= 1)
//   len   - interval length in sclk cycles
//   done  - one-cycle pulse when the count reaches zero
// -----------------------------------------------------------------------------
module pulse_timer
  import vend_pkg::*;
(
  input  logic               sclk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] len,
  output logic               done
);

  logic [TIMER_W-1:0] count;
  logic               running;

  assign done = running && (count == '0);

  // NOTE: sequential state uses non-blocking assignments and is cleared by the
  // asynchronous reset so every register leaves reset in a known value.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= len - TIMER_W'(1);
      running <= 1'b1;
    end else if (running) begin
      if (count == '0) begin
        running <= 1'b0;
      end else begin
        count <= count - TIMER_W'(1);
      end
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// -----------------------------------------------------------------------------
// vend_sequencer
// Credit-and-dispense controller for the cola vending machine. Accumulates
// credit from coin pulses, drives a timed dispense pulse when the price is
// reached, then returns any remaining credit as a train of timed change
// pulses (one 0.5-yuan coin each). Every pulse is followed by an idle gap.
//
// Parameters:
//   PRICE     - cola price in 0.5-yuan units (1..12)
//   PULSE_CYC - actuator pulse length in sclk cycles (>= 1)
//   GAP_CYC   - idle gap after each pulse in sclk cycles (>= 1)
//
// Ports:
//   sclk        - system clock
//   rst_n       - asynchronous active-low reset
//   coin_half   - one-cycle pulse, 0.5 yuan inserted
//   coin_one    - one-cycle pulse, 1.0 yuan inserted
//   cancel      - one-cycle pulse, refund request
//   po_cola     - dispense actuator
//   po_money    - change actuator, one 0.5-yuan coin per pulse
//   coin_reject - one-cycle pulse after a coin arrives while busy
//   credit      - current credit in 0.5-yuan units
//   busy        - high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE     = 5,
  parameter int PULSE_CYC = 5_000_000,
  parameter int GAP_CYC   = 5_000_000
) (
  input  logic                sclk,
  input  logic                rst_n,
  input  logic                coin_half,
  input  logic                coin_one,
  input  logic                cancel,
  output logic                po_cola,
  output logic                po_money,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [CREDIT_W:0]   PRICE_W   = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]   UNIT_W    = (CREDIT_W+1)'(1);
  localparam logic [CREDIT_W-1:0] UNIT      = CREDIT_W'(1);
  localparam logic [TIMER_W-1:0]  PULSE_LEN = TIMER_W'(PULSE_CYC);
  localparam logic [TIMER_W-1:0]  GAP_LEN   = TIMER_W'(GAP_CYC);

  state_t             state;
  logic [CREDIT_W:0]  add;
  logic [CREDIT_W:0]  sum;
  logic               vend_now;
  logic               refund_now;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_len;
  logic               timer_done;

  // One extra bit on the sum: credit + 3 can exceed 4 bits before the
  // price is subtracted.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    add = '0;
    if (coin_half) add = add + {1'b0, HALF};
    if (coin_one)  add = add + {1'b0, ONE};
    sum        = {1'b0, credit} + add;
    vend_now   = (sum >= PRICE_W);
    refund_now = cancel && (sum != '0);
  end

  // The timer is (re)loaded on the same edge that enters a timed state, so
  // its done pulse lines up with the edge that must leave that state.
  always_comb begin
    timer_load = 1'b0;
    timer_len  = PULSE_LEN;
    unique case (state)
      IDLE: begin
        timer_load = vend_now || refund_now;
      end
      VEND, CHANGE: begin
        timer_load = timer_done;
        timer_len  = GAP_LEN;
      end
      GAP: begin
        timer_load = timer_done && (credit != '0);
      end
      default: ;
    endcase
  end

  pulse_timer u_pulse_timer (
    .sclk  (sclk),
    .rst_n (rst_n),
    .load  (timer_load),
    .len   (timer_len),
    .done  (timer_done)
  );

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      credit      <= '0;
      po_cola     <= 1'b0;
      po_money    <= 1'b0;
      coin_reject <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // Coins arriving outside IDLE are refused; two at once give one reject.
      coin_reject <= (state != IDLE) && (coin_half || coin_one);

      unique case (state)
        IDLE: begin
          if (vend_now) begin
            state   <= VEND;
            credit  <= CREDIT_W'(sum - PRICE_W);
            po_cola <= 1'b1;
            busy    <= 1'b1;
          end else if (refund_now) begin
            state    <= CHANGE;
            credit   <= CREDIT_W'(sum - UNIT_W);
            po_money <= 1'b1;
            busy     <= 1'b1;
          end else begin
            credit <= sum[CREDIT_W-1:0];
          end
        end

        VEND, CHANGE: begin
          if (timer_done) begin
            state    <= GAP;
            po_cola  <= 1'b0;
            po_money <= 1'b0;
          end
        end

        GAP: begin
          if (timer_done) begin
            if (credit != '0) begin
              // Each change pulse hands back one 0.5-yuan coin.
              state    <= CHANGE;
              credit   <= credit - UNIT;
              po_money <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vend_sequencer
// Directed bench for vend_sequencer with PRICE=5, PULSE_CYC=4, GAP_CYC=2.
// Inputs are driven 1 ns after the rising edge and outputs are sampled there,
// so each sample reflects the state registered by the preceding edge.
// -----------------------------------------------------------------------------
module tb_vend_sequencer;

  localparam int PRICE     = 5;
  localparam int PULSE_CYC = 4;
  localparam int GAP_CYC   = 2;
  localparam int SEG       = PULSE_CYC + GAP_CYC;

  logic       sclk      = 1'b0;
  logic       rst_n     = 1'b0;
  logic       coin_half = 1'b0;
  logic       coin_one  = 1'b0;
  logic       cancel    = 1'b0;
  logic       po_cola;
  logic       po_money;
  logic       coin_reject;
  logic [3:0] credit;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 sclk = ~sclk;

  vend_sequencer #(
    .PRICE     (PRICE),
    .PULSE_CYC (PULSE_CYC),
    .GAP_CYC   (GAP_CYC)
  ) dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .coin_half   (coin_half),
    .coin_one    (coin_one),
    .cancel      (cancel),
    .po_cola     (po_cola),
    .po_money    (po_money),
    .coin_reject (coin_reject),
    .credit      (credit),
    .busy        (busy)
  );

  task automatic cyc();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic cola, input logic money,
                            input logic rej, input logic [3:0] cr, input logic bsy);
    check({tag, " po_cola"},     32'(po_cola),     32'(cola));
    check({tag, " po_money"},    32'(po_money),    32'(money));
    check({tag, " coin_reject"}, 32'(coin_reject), 32'(rej));
    check({tag, " credit"},      32'(credit),      32'(cr));
    check({tag, " busy"},        32'(busy),        32'(bsy));
  endtask

  // Apply one cycle of coin/cancel input in IDLE.
  task automatic pulse_in(input logic h, input logic o, input logic c);
    coin_half = h;
    coin_one  = o;
    cancel    = c;
    cyc();
    coin_half = 1'b0;
    coin_one  = 1'b0;
    cancel    = 1'b0;
  endtask

  // Follows a busy episode cycle by cycle, starting in the first cycle after
  // the triggering edge (k=0). The episode is an optional vend segment then
  // n_money change segments, each PULSE_CYC high plus GAP_CYC low, followed
  // by IDLE. 'inj' >= 0 drives coins (h/o) plus cancel during cycle 'inj';
  // a reject is expected in cycle inj+1 and nothing else may change.
  task automatic run_sequence(input string tag, input bit vend, input int n_money,
                              input int inj, input logic h, input logic o);
    int   segs;
    int   last;
    int   s;
    bit   hi;
    logic e_cola;
    logic e_money;
    logic e_rej;
    logic [3:0] e_cr;
    segs = (vend ? 1 : 0) + n_money;
    last = SEG * segs;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin
        if (k - 1 == inj) begin
          coin_half = h;
          coin_one  = o;
          cancel    = 1'b1;
        end
        cyc();
        coin_half = 1'b0;
        coin_one  = 1'b0;
        cancel    = 1'b0;
      end
      s       = k / SEG;
      hi      = (k < last) && ((k % SEG) < PULSE_CYC);
      e_cola  = vend && (s == 0) && hi;
      e_money = hi && (!vend || (s >= 1));
      e_rej   = (inj >= 0) && (k - 1 == inj);
      if (k >= last)  e_cr = 4'd0;
      else if (vend)  e_cr = 4'(n_money - s);
      else            e_cr = 4'(n_money - 1 - s);
      check_outs($sformatf("%s k=%0d", tag, k), e_cola, e_money, e_rej, e_cr, k < last);
    end
  endtask

  initial begin
    // Reset state.
    cyc();
    cyc();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    cyc();
    check_outs("post_reset", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // Cancel with zero credit is a no-op.
    pulse_in(1'b0, 1'b0, 1'b1);
    check_outs("cancel_zero", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

    // 1: five half coins, 3 cycles apart -> exact price, no change.
    for (int i = 1; i <= 4; i++) begin
      pulse_in(1'b1, 1'b0, 1'b0);
      check_outs($sformatf("s1 coin%0d", i), 1'b0, 1'b0, 1'b0, 4'(i), 1'b0);
      cyc();
      cyc();
      check($sformatf("s1 hold%0d credit", i), 32'(credit), 32'(i));
    end
    pulse_in(1'b1, 1'b0, 1'b0);
    run_sequence("s1", 1'b1, 0, -1, 1'b0, 1'b0);

    // 2: three one-yuan coins back to back -> vend plus one change pulse.
    pulse_in(1'b0, 1'b1, 1'b0);
    check_outs("s2 coin1", 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
    pulse_in(1'b0, 1'b1, 1'b0);
    check_outs("s2 coin2", 1'b0, 1'b0, 1'b0, 4'd4, 1'b0);
    pulse_in(1'b0, 1'b1, 1'b0);
    run_sequence("s2", 1'b1, 1, -1, 1'b0, 1'b0);

    // 3: both coins in one cycle, twice -> 3 then 6, same as scenario 2.
    pulse_in(1'b1, 1'b1, 1'b0);
    check_outs("s3 pair1", 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
    pulse_in(1'b1, 1'b1, 1'b0);
    run_sequence("s3", 1'b1, 1, -1, 1'b0, 1'b0);

    // 4: 2 yuan then cancel -> four change pulses; a double coin (with a
    // cancel) during the second pulse gives one reject and nothing else.
    pulse_in(1'b0, 1'b1, 1'b0);
    pulse_in(1'b0, 1'b1, 1'b0);
    check_outs("s4 credit4", 1'b0, 1'b0, 1'b0, 4'd4, 1'b0);
    pulse_in(1'b0, 1'b0, 1'b1);
    run_sequence("s4", 1'b0, 4, SEG + 1, 1'b1, 1'b1);

    // 5: coin_one during VEND -> reject next cycle, credit and timing intact.
    pulse_in(1'b0, 1'b1, 1'b0);
    pulse_in(1'b0, 1'b1, 1'b0);
    pulse_in(1'b1, 1'b0, 1'b0);
    run_sequence("s5", 1'b1, 0, 0, 1'b0, 1'b1);

    // 6: asynchronous reset two cycles into VEND with 0.5 yuan of change owed.
    pulse_in(1'b0, 1'b1, 1'b0);
    pulse_in(1'b0, 1'b1, 1'b0);
    pulse_in(1'b0, 1'b1, 1'b0);
    check_outs("s6 vend", 1'b1, 1'b0, 1'b0, 4'd1, 1'b1);
    cyc();
    cyc();
    check_outs("s6 vend2", 1'b1, 1'b0, 1'b0, 4'd1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("s6 async", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    check_outs("s6 idle", 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    pulse_in(1'b1, 1'b0, 1'b0);
    check_outs("s6 resume", 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
